uart_word_tx: RTL



---
 rtl/uart_word_tx_if.sv | 10 +
 rtl/uart_word_tx.sv | 132 +++++++++++++
 2 files changed

// File: rtl/uart_word_tx_if.sv
// uart_word_tx_if: valid/ready word handshake between the solver core and the UART word sender.
interface uart_word_tx_if #(
    parameter int WORD_BYTES = 8
);
    logic [8*WORD_BYTES-1:0] word_in;
    logic                    word_valid;
    logic                    word_ready;
    modport master (output word_in, output word_valid, input word_ready);
    modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/uart_word_tx.sv
// uart_word_tx: sends a multi-byte word MSB byte first as UART frames with configurable parity, stop bits and gap.
module uart_word_tx #(
    parameter int CLK_FREQ   = 12_000_000,
    parameter int BAUD_RATE  = 921_600,
    parameter int WORD_BYTES = 8,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 1,
    parameter int GAP_BITS   = 0
) (
    input  logic          sysclk,
    input  logic          rst_n,
    uart_word_tx_if.slave word_if,
    output logic          uart_rxd_out,
    output logic          busy,
    output logic          byte_strobe,
    output logic          done
);
    localparam int CPB     = CLK_FREQ / BAUD_RATE;
    localparam int TW      = CPB > 2 ? $clog2(CPB) : 1;
    localparam int BW      = WORD_BYTES > 1 ? $clog2(WORD_BYTES) : 1;
    localparam int W       = 8 * WORD_BYTES;
    localparam bit HAS_PAR = PARITY != 0;
    localparam bit HAS_GAP = GAP_BITS != 0;
    localparam bit ODD     = PARITY == 2;

    if (STOP_BITS < 1 || STOP_BITS > 2 || PARITY < 0 || PARITY > 2 || CPB < 2) begin : g_bad_param
        $error("uart_word_tx: unsupported STOP_BITS/PARITY/CLK_FREQ/BAUD_RATE combination");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, GAP} state_t;

    state_t          state_q;
    logic [W-1:0]    word_q;
    logic [7:0]      cur_q;
    logic            par_q;
    logic [3:0]      cnt_q;
    logic [TW-1:0]   timer_q;
    logic [BW-1:0]   bc_q;
    logic            line_q, ready_q, busy_q, strobe_q, done_q;
    logic            tick, stop_last, next_byte, load;
    logic [7:0]      nxt;

    // cnt_q counts data bits, stop bits or gap periods depending on the state
    always_comb begin
        tick      = timer_q == '0;
        stop_last = cnt_q == 4'(STOP_BITS - 1);
        next_byte = tick && ((state_q == STOP && stop_last && bc_q != '0 && !HAS_GAP) ||
                             (state_q == GAP && cnt_q == 4'(GAP_BITS - 1)));
        load      = next_byte || (state_q == IDLE && word_if.word_valid);
        nxt       = state_q == IDLE ? word_if.word_in[W-1 -: 8] : word_q[W-1 -: 8];
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            word_q   <= '0;
            cur_q    <= '0;
            par_q    <= 1'b0;
            cnt_q    <= '0;
            timer_q  <= '0;
            bc_q     <= '0;
            line_q   <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            if (state_q == IDLE) begin
                if (word_if.word_valid) begin
                    word_q  <= word_if.word_in << 8;
                    bc_q    <= BW'(WORD_BYTES - 1);
                    ready_q <= 1'b0;
                    busy_q  <= 1'b1;
                end
            end else if (!tick) begin
                timer_q <= timer_q - 1'b1;
            end else begin
                timer_q <= TW'(CPB - 1);
                cnt_q   <= '0;
                case (state_q)
                    START: begin
                        state_q <= DATA;
                        line_q  <= cur_q[0];
                        cur_q   <= cur_q >> 1;
                    end
                    DATA: if (cnt_q == 4'd7) begin
                        state_q <= HAS_PAR ? PAR : STOP;
                        line_q  <= HAS_PAR ? par_q : 1'b1;
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                        line_q <= cur_q[0];
                        cur_q  <= cur_q >> 1;
                    end
                    PAR: begin
                        state_q <= STOP;
                        line_q  <= 1'b1;
                    end
                    STOP: if (!stop_last) cnt_q <= cnt_q + 1'b1;
                    else if (bc_q == '0) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (HAS_GAP) state_q <= GAP;
                    GAP: if (cnt_q != 4'(GAP_BITS - 1)) cnt_q <= cnt_q + 1'b1;
                    default: state_q <= IDLE;
                endcase
            end
            // a new frame starts either from IDLE on accept or straight out of STOP/GAP
            if (load) begin
                state_q  <= START;
                line_q   <= 1'b0;
                strobe_q <= 1'b1;
                timer_q  <= TW'(CPB - 1);
                cur_q    <= nxt;
                par_q    <= (^nxt) ^ ODD;
            end
            if (next_byte) begin
                word_q <= word_q << 8;
                bc_q   <= bc_q - 1'b1;
            end
        end
    end

    assign word_if.word_ready = ready_q;
    assign uart_rxd_out       = line_q;
    assign busy               = busy_q;
    assign byte_strobe        = strobe_q;
    assign done               = done_q;
endmodule
